// File: rtl/imem_pkg.sv
// Shared AHB3-Lite encodings, instruction constants and responder state type.
package imem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0]  HSIZE_WORD = 3'b010;
    localparam int unsigned WORD_W     = 32;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
    function automatic logic htrans_active(input logic [1:0] trans);
        return !(trans == HTRANS_IDLE || trans == HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/imem_store.sv
// Word-addressed instruction store: synchronous load/NOP-fill, asynchronous read.
module imem_store
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [WORD_W-1:0] rdata_c
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Reset fill takes priority over a load on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= NOP_INSN;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata_c = mem[ridx];

endmodule

// File: rtl/ahb3lite_imem_responder.sv
// AHB3-Lite instruction-fetch responder with configurable wait states and
// two-cycle ERROR response for illegal accesses.
module ahb3lite_imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned           HADDR_SIZE = 32,
    parameter int unsigned           HDATA_SIZE = 32,
    parameter int unsigned           MEM_DEPTH  = 64,
    parameter logic [HADDR_SIZE-1:0] BASE_ADDR  = HADDR_SIZE'(32'h200),
    parameter int unsigned           MAX_WAIT   = 3,
    parameter int unsigned           WAIT_W     = $clog2(MAX_WAIT + 1),
    parameter int unsigned           IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    input  logic [WAIT_W-1:0]     wait_cfg,
    input  logic                  load_we,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [31:0]           load_data,
    output logic [31:0]           fetch_cnt
);

    localparam logic [HADDR_SIZE-1:0] SPAN = HADDR_SIZE'(4 * MEM_DEPTH);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                  accept_c, legal_c, ready_cyc_c, can_accept_c;
    logic [HADDR_SIZE-1:0] off_c;
    logic [WAIT_W-1:0]     wait_clamped_c;
    logic [WORD_W-1:0]     store_rdata_c, word_c;
    logic                  hreadyout_d, hresp_d;
    logic [HDATA_SIZE-1:0] hrdata_d;

    imem_store #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_store (
        .clk     (HCLK),
        .rst     (HRESET),
        .we      (load_we),
        .widx    (load_idx),
        .wdata   (load_data),
        .ridx    (idx_d),
        .rdata_c (store_rdata_c)
    );

    // Address-phase decode.
    assign accept_c       = HSEL && HREADY && htrans_active(HTRANS);
    assign off_c          = HADDR - BASE_ADDR;
    assign legal_c        = !HWRITE && (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00)
                            && (HADDR >= BASE_ADDR) && (off_c < SPAN);
    assign wait_clamped_c = ({1'b0, wait_cfg} > (WAIT_W + 1)'(MAX_WAIT))
                            ? WAIT_W'(MAX_WAIT) : wait_cfg;
    assign ready_cyc_c    = (state_q == ST_RD) && (wcnt_q == '0);
    assign can_accept_c   = (state_q == ST_IDLE) || ready_cyc_c || (state_q == ST_ERR2);

    // Same-edge loads are forwarded so the ready cycle sees the newest word.
    assign word_c = (load_we && (load_idx == idx_d)) ? load_data : store_rdata_c;

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        idx_d       = idx_q;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        hrdata_d    = '0;

        case (state_q)
            ST_RD: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WAIT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        if (can_accept_c && accept_c) begin
            if (legal_c) begin
                state_d = ST_RD;
                wcnt_d  = wait_clamped_c;
                idx_d   = off_c[IDX_W+1:2];
            end else begin
                state_d = ST_ERR1;
            end
        end

        case (state_d)
            ST_RD: begin
                if (wcnt_d != '0) begin
                    hreadyout_d = 1'b0;
                end else begin
                    hrdata_d = HDATA_SIZE'(word_c);
                end
            end
            ST_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_ERROR;
            end
            ST_ERR2: hresp_d = HRESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            idx_q     <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            fetch_cnt <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            HREADYOUT <= hreadyout_d;
            HRESP     <= hresp_d;
            HRDATA    <= hrdata_d;
            if (ready_cyc_c) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule
